// File: rtl/gray_seq_ctrl.sv
// Command-driven binary/Gray counter sequencer: LOAD/STEP/RUN/NOP over a valid/ready port.
// Optional GRAY_SEQ_PAUSE_EN adds a pause input that stalls an active RUN.
module gray_seq_ctrl #(
    parameter int DATA_WIDTH = 4,
    parameter int STEP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic                  cmd_dir,
    input  logic [DATA_WIDTH-1:0] cmd_load,
    input  logic [STEP_WIDTH-1:0] cmd_count,
    input  logic                  abort,
`ifdef GRAY_SEQ_PAUSE_EN
    input  logic                  pause,
`endif
    output logic [DATA_WIDTH-1:0] gray_out,
    output logic [DATA_WIDTH-1:0] bin_out,
    output logic                  busy,
    output logic                  done,
    output logic                  wrapped,
    output logic                  aborted
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_STEP = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    state_t                state;
    logic [STEP_WIDTH-1:0] remaining;
    logic                  run_dir;
    logic                  step_dir;
    logic                  step_wrap;
    logic [DATA_WIDTH-1:0] step_bin;
    logic                  hold;

    function automatic logic [DATA_WIDTH-1:0] to_gray(input logic [DATA_WIDTH-1:0] b);
        to_gray = b ^ (b >> 1);
    endfunction

    // MSB of the result flags a crossing between all-ones and zero.
    function automatic logic [DATA_WIDTH:0] step_val(input logic [DATA_WIDTH-1:0] b,
                                                     input logic dn);
        if (dn)
            step_val = {(b == '0), b - DATA_WIDTH'(1)};
        else
            step_val = {(&b), b + DATA_WIDTH'(1)};
    endfunction

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state == S_RUN);

`ifdef GRAY_SEQ_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        step_dir              = (state == S_RUN) ? run_dir : cmd_dir;
        {step_wrap, step_bin} = step_val(bin_out, step_dir);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            run_dir   <= 1'b0;
            bin_out   <= '0;
            gray_out  <= '0;
            done      <= 1'b0;
            wrapped   <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            done    <= 1'b0;
            wrapped <= 1'b0;
            aborted <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_LOAD: begin
                                bin_out  <= cmd_load;
                                gray_out <= to_gray(cmd_load);
                                done     <= 1'b1;
                            end
                            OP_STEP: begin
                                bin_out  <= step_bin;
                                gray_out <= to_gray(step_bin);
                                wrapped  <= step_wrap;
                                done     <= 1'b1;
                            end
                            OP_RUN: begin
                                if (cmd_count == '0) begin
                                    done <= 1'b1;
                                end else begin
                                    state     <= S_RUN;
                                    remaining <= cmd_count;
                                    run_dir   <= cmd_dir;
                                end
                            end
                            OP_NOP:  done <= 1'b1;
                            default: done <= 1'b1;
                        endcase
                    end
                end
                S_RUN: begin
                    // Abort beats both pause and the final step.
                    if (abort) begin
                        state     <= S_IDLE;
                        remaining <= '0;
                        aborted   <= 1'b1;
                    end else if (!hold) begin
                        bin_out   <= step_bin;
                        gray_out  <= to_gray(step_bin);
                        wrapped   <= step_wrap;
                        remaining <= remaining - STEP_WIDTH'(1);
                        if (remaining == STEP_WIDTH'(1)) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Bench for gray_seq_ctrl: directed vector table, corner sequences, random run vs integer model.
module tb_gray_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_dir;
    logic [3:0] cmd_load;
    logic [7:0] cmd_count;
    logic       abort;
    logic       pause;
    logic [3:0] gray_out;
    logic [3:0] bin_out;
    logic       busy;
    logic       done;
    logic       wrapped;
    logic       aborted;

    always #5 clk = ~clk;

    gray_seq_ctrl #(.DATA_WIDTH(4), .STEP_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dir   (cmd_dir),
        .cmd_load  (cmd_load),
        .cmd_count (cmd_count),
        .abort     (abort),
`ifdef GRAY_SEQ_PAUSE_EN
        .pause     (pause),
`endif
        .gray_out  (gray_out),
        .bin_out   (bin_out),
        .busy      (busy),
        .done      (done),
        .wrapped   (wrapped),
        .aborted   (aborted)
    );

    typedef struct {
        logic        rst;
        logic        v;
        logic [1:0]  op;
        logic        dir;
        logic [3:0]  load;
        logic [7:0]  cnt;
        logic        abt;
        logic [12:0] expv;   // {ready,busy,done,wrapped,aborted,bin,gray}
    } vec_t;

    vec_t tbl[$];
    int   n_pass = 0;
    int   n_total = 0;

    // Reference model: pending RUN steps as an integer, count as an integer mod 16.
    int   m_bin;
    int   m_left;
    bit   m_dir;
    bit   m_done, m_wrap, m_abt, m_stepped;

    function automatic vec_t mk(input logic rst, v, input logic [1:0] op, input logic dir,
                                input logic [3:0] load, input logic [7:0] cnt, input logic abt,
                                input logic rdy, bsy, dn, wr, ab, input logic [3:0] b, g);
        vec_t r;
        r.rst = rst; r.v = v; r.op = op; r.dir = dir; r.load = load; r.cnt = cnt; r.abt = abt;
        r.expv = {rdy, bsy, dn, wr, ab, b, g};
        return r;
    endfunction

    function automatic logic [12:0] dut_vec();
        return {cmd_ready, busy, done, wrapped, aborted, bin_out, gray_out};
    endfunction

    function automatic logic [12:0] model_vec();
        logic [3:0] b;
        b = 4'(m_bin);
        return {(m_left == 0), (m_left > 0), m_done, m_wrap, m_abt, b, b ^ (b >> 1)};
    endfunction

    task automatic check(input string nm, input logic [12:0] act, input logic [12:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (rdy,busy,done,wrap,abt,bin,gray)", nm, act, exp);
    endtask

    task automatic model_move(input bit dn);
        int nb;
        nb = dn ? m_bin - 1 : m_bin + 1;
        m_wrap = (nb < 0) || (nb > 15);
        m_bin = (nb + 16) % 16;
        m_stepped = 1;
    endtask

    task automatic model_edge();
        m_done = 0; m_wrap = 0; m_abt = 0; m_stepped = 0;
        if (reset) begin
            m_bin = 0; m_left = 0;
        end else if (m_left > 0) begin
            if (abort) begin
                m_left = 0; m_abt = 1;
            end else begin
                model_move(m_dir);
                m_left--;
                if (m_left == 0) m_done = 1;
            end
        end else if (cmd_valid) begin
            case (cmd_op)
                2'd0: begin m_bin = int'(cmd_load); m_done = 1; end
                2'd1: begin model_move(cmd_dir); m_done = 1; end
                2'd2: begin
                    if (cmd_count == 0) m_done = 1;
                    else begin m_left = int'(cmd_count); m_dir = cmd_dir; end
                end
                default: m_done = 1;
            endcase
        end
    endtask

    task automatic drive(input vec_t r);
        reset = r.rst; cmd_valid = r.v; cmd_op = r.op; cmd_dir = r.dir;
        cmd_load = r.load; cmd_count = r.cnt; abort = r.abt;
        @(posedge clk);
        #1;
        model_edge();
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd3; cmd_dir = 1'b0;
        cmd_load = '0; cmd_count = '0; abort = 1'b0; pause = 1'b0;
        m_bin = 0; m_left = 0; m_dir = 0;

        //               rst v op dir load  cnt  abt   rdy bsy dn wr ab bin   gray
        tbl.push_back(mk(1, 0, 3, 0, 4'h0, 8'd0, 0,   1, 0, 0, 0, 0, 4'h0, 4'h0));
        tbl.push_back(mk(1, 0, 3, 0, 4'h0, 8'd0, 0,   1, 0, 0, 0, 0, 4'h0, 4'h0));
        tbl.push_back(mk(0, 0, 3, 0, 4'h0, 8'd0, 0,   1, 0, 0, 0, 0, 4'h0, 4'h0));
        tbl.push_back(mk(0, 1, 0, 0, 4'hA, 8'd0, 0,   1, 0, 1, 0, 0, 4'hA, 4'hF));
        tbl.push_back(mk(0, 1, 1, 0, 4'h0, 8'd0, 0,   1, 0, 1, 0, 0, 4'hB, 4'hE));
        tbl.push_back(mk(0, 0, 1, 0, 4'h0, 8'd0, 0,   1, 0, 0, 0, 0, 4'hB, 4'hE));
        tbl.push_back(mk(0, 1, 0, 0, 4'hD, 8'd0, 0,   1, 0, 1, 0, 0, 4'hD, 4'hB));
        tbl.push_back(mk(0, 1, 2, 0, 4'h0, 8'd5, 0,   0, 1, 0, 0, 0, 4'hD, 4'hB));
        tbl.push_back(mk(0, 0, 3, 0, 4'h0, 8'd0, 0,   0, 1, 0, 0, 0, 4'hE, 4'h9));
        tbl.push_back(mk(0, 1, 0, 0, 4'h5, 8'd0, 0,   0, 1, 0, 0, 0, 4'hF, 4'h8));
        tbl.push_back(mk(0, 0, 3, 0, 4'h0, 8'd0, 0,   0, 1, 0, 1, 0, 4'h0, 4'h0));
        tbl.push_back(mk(0, 0, 3, 0, 4'h0, 8'd0, 0,   0, 1, 0, 0, 0, 4'h1, 4'h1));
        tbl.push_back(mk(0, 0, 3, 0, 4'h0, 8'd0, 0,   1, 0, 1, 0, 0, 4'h2, 4'h3));
        tbl.push_back(mk(0, 1, 0, 0, 4'h1, 8'd0, 0,   1, 0, 1, 0, 0, 4'h1, 4'h1));
        tbl.push_back(mk(0, 1, 2, 1, 4'h0, 8'd3, 0,   0, 1, 0, 0, 0, 4'h1, 4'h1));
        tbl.push_back(mk(0, 0, 3, 0, 4'h0, 8'd0, 0,   0, 1, 0, 0, 0, 4'h0, 4'h0));
        tbl.push_back(mk(0, 0, 3, 0, 4'h0, 8'd0, 0,   0, 1, 0, 1, 0, 4'hF, 4'h8));
        tbl.push_back(mk(0, 0, 3, 0, 4'h0, 8'd0, 0,   1, 0, 1, 0, 0, 4'hE, 4'h9));
        tbl.push_back(mk(0, 1, 0, 0, 4'h0, 8'd0, 0,   1, 0, 1, 0, 0, 4'h0, 4'h0));
        tbl.push_back(mk(0, 1, 2, 0, 4'h0, 8'd10, 0,  0, 1, 0, 0, 0, 4'h0, 4'h0));
        tbl.push_back(mk(0, 0, 3, 0, 4'h0, 8'd0, 0,   0, 1, 0, 0, 0, 4'h1, 4'h1));
        tbl.push_back(mk(0, 0, 3, 0, 4'h0, 8'd0, 0,   0, 1, 0, 0, 0, 4'h2, 4'h3));
        tbl.push_back(mk(0, 0, 3, 0, 4'h0, 8'd0, 0,   0, 1, 0, 0, 0, 4'h3, 4'h2));
        tbl.push_back(mk(0, 0, 3, 0, 4'h0, 8'd0, 1,   1, 0, 0, 0, 1, 4'h3, 4'h2));
        tbl.push_back(mk(0, 0, 3, 0, 4'h0, 8'd0, 0,   1, 0, 0, 0, 0, 4'h3, 4'h2));
        tbl.push_back(mk(0, 1, 2, 0, 4'h0, 8'd0, 0,   1, 0, 1, 0, 0, 4'h3, 4'h2));
        tbl.push_back(mk(0, 1, 2, 0, 4'h0, 8'd8, 0,   0, 1, 0, 0, 0, 4'h3, 4'h2));
        tbl.push_back(mk(0, 0, 3, 0, 4'h0, 8'd0, 0,   0, 1, 0, 0, 0, 4'h4, 4'h6));
        tbl.push_back(mk(1, 0, 3, 0, 4'h0, 8'd0, 0,   1, 0, 0, 0, 0, 4'h0, 4'h0));
        tbl.push_back(mk(0, 0, 3, 0, 4'h0, 8'd0, 0,   1, 0, 0, 0, 0, 4'h0, 4'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            check($sformatf("vec%0d", i), dut_vec(), tbl[i].expv);
        end

        // Abort in IDLE is ignored alongside a STEP; abort with one step left wins.
        drive(mk(0, 1, 1, 0, 4'h0, 8'd0, 1,  1, 0, 1, 0, 0, 4'h1, 4'h1));
        check("idle_abort_step", dut_vec(), 13'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 4'h1}));
        drive(mk(0, 1, 2, 0, 4'h0, 8'd1, 0,  0, 1, 0, 0, 0, 4'h1, 4'h1));
        check("run1_accept", dut_vec(), 13'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 4'h1}));
        drive(mk(0, 0, 3, 0, 4'h0, 8'd0, 1,  1, 0, 0, 0, 1, 4'h1, 4'h1));
        check("abort_last_step", dut_vec(), 13'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 4'h1}));
        drive(mk(0, 1, 1, 1, 4'h0, 8'd0, 0,  1, 0, 1, 0, 0, 4'h0, 4'h0));
        check("step_down_to0", dut_vec(), 13'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0}));
        drive(mk(0, 1, 1, 1, 4'h0, 8'd0, 0,  1, 0, 1, 1, 0, 4'hF, 4'h8));
        check("step_down_wrap", dut_vec(), 13'({1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 4'h8}));

        // Randomized traffic against the integer model.
        for (int i = 0; i < 600; i++) begin
            vec_t r;
            logic [3:0] prev_gray;
            prev_gray = gray_out;
            r.rst  = ($urandom_range(0, 63) == 0);
            r.v    = ($urandom_range(0, 9) < 7);
            r.op   = 2'($urandom_range(0, 3));
            r.dir  = 1'($urandom_range(0, 1));
            r.load = 4'($urandom_range(0, 15));
            r.cnt  = 8'($urandom_range(0, 6));
            r.abt  = ($urandom_range(0, 9) == 0);
            r.expv = '0;
            drive(r);
            check($sformatf("rand%0d", i), dut_vec(), model_vec());
            if (m_stepped && !r.rst)
                check($sformatf("rand%0d_onebit", i), 13'($countones(prev_gray ^ gray_out)), 13'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
